// File: rtl/cp_out_transmitter.sv
// Control-plane-out transmitter: buffers internal requests in a small FIFO and
// presents them one at a time on a valid/ready bus with a sequence tag and an optional stall timeout.
module cp_out_transmitter #(
    parameter int ADDR_WIDTH = 37,
    parameter int DATA_WIDTH = 28,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  cp_out_valid,
    input  logic                  cp_out_ready,
    output logic [ADDR_WIDTH-1:0] cp_out_addr,
    output logic [DATA_WIDTH-1:0] cp_out_data,
    output logic [7:0]            cp_out_seq,
    output logic                  timeout_err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [PW:0]   DEPTH_C  = (PW + 1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {IDLE, SEND} state_t;

    logic [EW-1:0] mem_q [FIFO_DEPTH];

    state_t                state_q, state_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW:0]           count_q, count_d;
    logic                  req_ready_q, req_ready_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [7:0]            seq_q, seq_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  timeout_err_q, timeout_err_d;

    logic push, pop, handshake, expire, release_out, fifo_empty;

    always_comb begin
        push        = req_valid & req_ready_q;
        fifo_empty  = (count_q == '0);
        handshake   = (state_q == SEND) & cp_out_ready;
        // Ready on the final stall cycle wins over the timeout.
        expire      = (TIMEOUT > 0) & (state_q == SEND) & ~cp_out_ready & (tmo_q == TMO_LAST);
        release_out = handshake | expire;
        pop         = ~fifo_empty & ((state_q == IDLE) | release_out);
    end

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        addr_d        = addr_q;
        data_d        = data_q;
        seq_d         = seq_q;
        tmo_d         = tmo_q;
        timeout_err_d = expire;

        if (pop) begin
            {addr_d, data_d} = mem_q[rd_ptr_q];
            rd_ptr_d         = rd_ptr_q + PW'(1);
            state_d          = SEND;
            tmo_d            = '0;
        end else if (release_out) begin
            state_d = IDLE;
            tmo_d   = '0;
        end else if ((TIMEOUT > 0) && (state_q == SEND) && !cp_out_ready) begin
            tmo_d = tmo_q + TW'(1);
        end

        if (handshake) begin
            seq_d = seq_q + 8'd1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        if (push && !pop) begin
            count_d = count_q + (PW + 1)'(1);
        end else if (!push && pop) begin
            count_d = count_q - (PW + 1)'(1);
        end

        req_ready_d = (count_d < DEPTH_C);
    end

    // Buffer storage carries no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req_addr, req_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            req_ready_q   <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            seq_q         <= '0;
            tmo_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            req_ready_q   <= req_ready_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            seq_q         <= seq_d;
            tmo_q         <= tmo_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign cp_out_valid = (state_q == SEND);
    assign cp_out_addr  = addr_q;
    assign cp_out_data  = data_q;
    assign cp_out_seq   = seq_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: doc/cp_out_transmitter.md
CP_OUT_TRANSMITTER -- requirements
Module: cp_out_transmitter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 37, control-plane-out address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 28, control-plane-out data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, request buffer entries (power of 2, >=2).
REQ-004 SHALL have parameter TIMEOUT, default 16, max cycles valid is held without ready; 0 disables the timeout.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port req_valid  input  1  internal request present.
REQ-008 SHALL have port req_ready  output  1  buffer can accept a request.
REQ-009 SHALL have port req_addr  input  ADDR_WIDTH  request address.
REQ-010 SHALL have port req_data  input  DATA_WIDTH  request data.
REQ-011 SHALL have port cp_out_valid  output  1  transfer offered on the control-plane-out bus.
REQ-012 SHALL have port cp_out_ready  input  1  receiver accepts the transfer.
REQ-013 SHALL have port cp_out_addr  output  ADDR_WIDTH  transfer address.
REQ-014 SHALL have port cp_out_data  output  DATA_WIDTH  transfer data.
REQ-015 SHALL have port cp_out_seq  output  8  transfer sequence tag.
REQ-016 SHALL have port timeout_err  output  1  one-cycle pulse when a transfer is aborted.

Function
REQ-017 SHALL accept a request on a cycle with req_valid=1 and req_ready=1, writing {addr,data} to the FIFO tail.
REQ-018 SHALL drive req_ready = (FIFO occupancy < FIFO_DEPTH), registered, with no combinational dependence on cp_out_ready or req_valid.
REQ-019 SHALL implement FSM states IDLE and SEND; in IDLE, cp_out_valid=0.
REQ-020 SHALL, in IDLE with FIFO non-empty, pop the head into the registered output stage, set cp_out_valid=1 next cycle, and go to SEND.
REQ-021 SHALL give latency of exactly 2 cycles from request acceptance (FIFO empty, IDLE) to cp_out_valid=1.
REQ-022 SHALL hold cp_out_addr, cp_out_data and cp_out_seq stable while cp_out_valid=1 and cp_out_ready=0.
REQ-023 SHALL, on handshake (cp_out_valid & cp_out_ready) with FIFO non-empty, load the next head in the same edge and stay in SEND, sustaining one transfer per cycle.
REQ-024 SHALL, on handshake with FIFO empty, return to IDLE with cp_out_valid=0 next cycle.
REQ-025 SHALL increment cp_out_seq by 1 modulo 256 on every completed handshake; 255 wraps to 0.
REQ-026 SHALL, when TIMEOUT>0 and cp_out_valid has been 1 without ready for TIMEOUT consecutive cycles, drop the transfer, pulse timeout_err for one cycle, leave cp_out_seq unchanged, and proceed as in REQ-023/REQ-024.
REQ-027 SHALL reset the timeout counter on every handshake and on every new transfer load.
REQ-028 SHALL treat cp_out_ready sampled as 1 on the timeout cycle as a handshake, with no timeout_err.
REQ-029 SHALL handle a simultaneous push and pop with occupancy unchanged; when full, a pop frees a slot visible on req_ready the following cycle.
REQ-030 SHALL ignore req_addr/req_data when req_valid=0 or req_ready=0.

Reset
REQ-031 SHALL, on rst assertion, immediately force cp_out_valid=0, req_ready=0, timeout_err=0, cp_out_seq=0, cp_out_addr=0, cp_out_data=0, FIFO empty, FSM IDLE, timeout counter 0.
REQ-032 SHALL discard any in-flight or buffered transfer when rst is asserted mid-operation, with no handshake or error reported.
REQ-033 SHALL assert req_ready=1 on the first rising edge after rst deasserts.

Verification
REQ-034 SHALL cover single request: addr=0x1_0000_00AB, data=0x0ABCDEF, ready held 1 -> cp_out_valid 2 cycles later with those values, seq=0, then IDLE.
REQ-035 SHALL cover backpressure fill: 6 requests with ready=0 and TIMEOUT=0 -> req_ready drops after 5 accepts (4 FIFO + 1 output); ready=1 -> 5 back-to-back transfers with seq 0..4, in order.
REQ-036 SHALL cover timeout: ready=0 for 16 cycles -> timeout_err pulses once, transfer dropped, next transfer carries seq=0.
REQ-037 SHALL cover seq wrap: 257 transfers -> seq runs 0..255, 0.
REQ-038 SHALL cover mid-reset: rst during SEND with 3 entries buffered -> outputs per REQ-031 on the same cycle; after release, no stale transfer appears.
REQ-039 SHALL cover ready-on-timeout-cycle: ready rises on cycle 16 -> handshake, no timeout_err, seq increments.
